// File: rtl/cfg_dprio_readdata_capture.sv
// DPRIO read-data capture: sequences one outstanding read, waits for the
// select/mux tree to settle, registers the result and returns it with a
// single-cycle valid/ack handshake. Unclaimed addresses return DEFAULT_DATA
// together with an error pulse.
module cfg_dprio_readdata_capture #(
  parameter int unsigned                DATA_WIDTH   = 16,
  parameter int unsigned                READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0]      DEFAULT_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  addr_hit,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  rd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; outputs depend on registered state only
  always_comb begin
    state_nxt     = state;
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    rd_err        = 1'b0;
    case (state)
      IDLE: begin
        if (read) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!read) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt     = IDLE;
        waitrequest   = 1'b0;
        readdatavalid = 1'b1;
        rd_err        = ~hit;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latency counter, sticky hit flag and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      hit      <= 1'b0;
      readdata <= DEFAULT_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            cnt <= CNT_LOAD;
            hit <= addr_hit;
          end
        end
        WAIT: begin
          hit <= hit | addr_hit;
          if (read) begin
            if (cnt == 4'd0) begin
              // hit is folded with the current addr_hit so a hit seen only
              // in the final wait cycle still selects data_in
              readdata <= (hit | addr_hit) ? data_in : DEFAULT_DATA;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_dprio_readdata_capture.sv
// Directed self-checking bench for cfg_dprio_readdata_capture.
// dut uses READ_LATENCY=2, dut1 uses READ_LATENCY=1.
module tb_cfg_dprio_readdata_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, addr_hit;
  logic [15:0] data_in;
  logic        waitrequest, readdatavalid, rd_err;
  logic [15:0] readdata;

  logic        read1, addr_hit1;
  logic [15:0] data_in1;
  logic        waitrequest1, readdatavalid1, rd_err1;
  logic [15:0] readdata1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cfg_dprio_readdata_capture #(
    .DATA_WIDTH  (16),
    .READ_LATENCY(2),
    .DEFAULT_DATA(16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read         (read),
    .addr_hit     (addr_hit),
    .data_in      (data_in),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .rd_err       (rd_err)
  );

  cfg_dprio_readdata_capture #(
    .DATA_WIDTH  (16),
    .READ_LATENCY(1),
    .DEFAULT_DATA(16'h0000)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .read         (read1),
    .addr_hit     (addr_hit1),
    .data_in      (data_in1),
    .waitrequest  (waitrequest1),
    .readdata     (readdata1),
    .readdatavalid(readdatavalid1),
    .rd_err       (rd_err1)
  );

  // Advance one cycle; outputs are observed 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; addr_hit = 1'b0; data_in = 16'h0000;
    read1 = 1'b0; addr_hit1 = 1'b0; data_in1 = 16'h0000;
    repeat (3) tick();
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: wr/rdv/err/data got %b%b%b %h expected 100 0000",
               waitrequest, readdatavalid, rd_err, readdata);
    end
    n_checks++;
    if ({waitrequest1, readdatavalid1, rd_err1, readdata1} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state_l1: wr/rdv/err/data got %b%b%b %h expected 100 0000",
               waitrequest1, readdatavalid1, rd_err1, readdata1);
    end
    reset = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_release: wr/rdv/err/data got %b%b%b %h expected 100 0000",
               waitrequest, readdatavalid, rd_err, readdata);
    end
  endtask

  task automatic test_basic_read();
    // cycle 0
    read = 1'b1; addr_hit = 1'b1; data_in = 16'hDEAD;
    tick();  // cycle 1
    n_checks++;
    if ({waitrequest, readdatavalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_c1: wr/rdv got %b%b expected 10", waitrequest, readdatavalid);
    end
    tick();  // cycle 2
    data_in = 16'hA5C3;
    n_checks++;
    if ({waitrequest, readdatavalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_c2: wr/rdv got %b%b expected 10", waitrequest, readdatavalid);
    end
    tick();  // cycle 3
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b010, 16'hA5C3}) begin
      n_fail++;
      $display("FAIL basic_done: wr/rdv/err/data got %b%b%b %h expected 010 a5c3",
               waitrequest, readdatavalid, rd_err, readdata);
    end
    read = 1'b0; addr_hit = 1'b0; data_in = 16'h0000;
    tick();  // cycle 4
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b100, 16'hA5C3}) begin
      n_fail++;
      $display("FAIL basic_hold: wr/rdv/err/data got %b%b%b %h expected 100 a5c3",
               waitrequest, readdatavalid, rd_err, readdata);
    end
  endtask

  task automatic test_late_data();
    read = 1'b1; addr_hit = 1'b1; data_in = 16'h0BAD;
    tick(); data_in = 16'h1111;
    tick(); data_in = 16'h2222;
    tick();
    n_checks++;
    if ({readdatavalid, rd_err, readdata} !== {2'b10, 16'h2222}) begin
      n_fail++;
      $display("FAIL late_data: rdv/err/data got %b%b %h expected 10 2222",
               readdatavalid, rd_err, readdata);
    end
    read = 1'b0; addr_hit = 1'b0;
    tick();
  endtask

  task automatic test_no_hit();
    read = 1'b1; addr_hit = 1'b0; data_in = 16'hFFFF;
    repeat (3) tick();
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b011, 16'h0000}) begin
      n_fail++;
      $display("FAIL no_hit: wr/rdv/err/data got %b%b%b %h expected 011 0000",
               waitrequest, readdatavalid, rd_err, readdata);
    end
    read = 1'b0;
    tick();
    n_checks++;
    if ({readdatavalid, rd_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_hit_end: rdv/err got %b%b expected 00", readdatavalid, rd_err);
    end
  endtask

  task automatic test_sticky_hit();
    read = 1'b1; addr_hit = 1'b0; data_in = 16'h00F0;
    tick(); addr_hit = 1'b1;
    tick(); addr_hit = 1'b0;
    tick();
    n_checks++;
    if ({readdatavalid, rd_err, readdata} !== {2'b10, 16'h00F0}) begin
      n_fail++;
      $display("FAIL sticky_hit: rdv/err/data got %b%b %h expected 10 00f0",
               readdatavalid, rd_err, readdata);
    end
    read = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int seen;
    // restore a known captured value first
    read = 1'b1; addr_hit = 1'b1; data_in = 16'hA5C3;
    repeat (3) tick();
    read = 1'b0;
    tick();
    n_checks++;
    if (readdata !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL abort_setup: data got %h expected a5c3", readdata);
    end
    // read drops in cycle 2
    read = 1'b1; addr_hit = 1'b1; data_in = 16'h7777;
    tick();
    tick(); read = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (readdatavalid !== 1'b0 || waitrequest !== 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_pulse: handshake cycles got %0d expected 0", seen);
    end
    n_checks++;
    if (readdata !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL abort_data: data got %h expected a5c3", readdata);
    end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    read = 1'b1; addr_hit = 1'b1; data_in = 16'h3C3C;
    tick();  // cycle 1, in WAIT
    reset = 1'b1;
    tick();
    n_checks++;
    if ({waitrequest, readdatavalid, rd_err, readdata} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_wait: wr/rdv/err/data got %b%b%b %h expected 100 0000",
               waitrequest, readdatavalid, rd_err, readdata);
    end
    reset = 1'b0; read = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (readdatavalid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0 || readdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_wait_after: pulses %0d data %h expected 0 0000", seen, readdata);
    end
  endtask

  task automatic test_back_to_back();
    // READ_LATENCY=1 instance, read held continuously through cycle 3
    read1 = 1'b1; addr_hit1 = 1'b1; data_in1 = 16'h1234;
    tick();  // cycle 1
    n_checks++;
    if ({waitrequest1, readdatavalid1} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_c1: wr/rdv got %b%b expected 10", waitrequest1, readdatavalid1);
    end
    tick();  // cycle 2
    n_checks++;
    if ({waitrequest1, readdatavalid1, rd_err1, readdata1} !== {3'b010, 16'h1234}) begin
      n_fail++;
      $display("FAIL b2b_done1: wr/rdv/err/data got %b%b%b %h expected 010 1234",
               waitrequest1, readdatavalid1, rd_err1, readdata1);
    end
    addr_hit1 = 1'b0;
    tick();  // cycle 3, IDLE accepting second read
    n_checks++;
    if ({waitrequest1, readdatavalid1} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_c3: wr/rdv got %b%b expected 10", waitrequest1, readdatavalid1);
    end
    tick();  // cycle 4, single WAIT cycle
    data_in1 = 16'h5678;
    n_checks++;
    if ({readdatavalid1, readdata1} !== {1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL b2b_c4: rdv/data got %b %h expected 0 1234", readdatavalid1, readdata1);
    end
    tick();  // cycle 5
    n_checks++;
    if ({waitrequest1, readdatavalid1, rd_err1, readdata1} !== {3'b011, 16'h0000}) begin
      n_fail++;
      $display("FAIL b2b_done2: wr/rdv/err/data got %b%b%b %h expected 011 0000",
               waitrequest1, readdatavalid1, rd_err1, readdata1);
    end
    read1 = 1'b0;
    tick();
    n_checks++;
    if ({waitrequest1, readdatavalid1} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_end: wr/rdv got %b%b expected 10", waitrequest1, readdatavalid1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_late_data();
    test_no_hit();
    test_sticky_hit();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_dprio_readdata_capture.md
Name: cfg_dprio_readdata_capture

Overview:
- Downstream consumer of the DPRIO read-data select stage.
- Sequences a single outstanding DPRIO read from the configuration master.
- Waits a fixed number of cycles for the selected block's read data to settle through the mux tree, then registers it and returns it with a one-cycle valid/ack handshake.
- Returns DEFAULT_DATA with an error flag when no block claims the address.

Parameters:
DATA_WIDTH, 16, width of read data path
READ_LATENCY, 2, cycles between read acceptance and mux output being stable; legal range 1..15
DEFAULT_DATA, 16'h0000, value returned when no block claimed the address (DATA_WIDTH bits)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
read  input  1  read request from config master; held high until waitrequest low
addr_hit  input  1  any downstream block decoded the address (OR of 1-hot selects)
data_in  input  DATA_WIDTH  read data from the select/mux stage
waitrequest  output  1  stall to master; low only in the completion cycle of a read
readdata  output  DATA_WIDTH  registered read data
readdatavalid  output  1  one-cycle pulse, readdata valid
rd_err  output  1  one-cycle pulse coincident with readdatavalid when no address hit occurred

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset (sampled on clk edge while reset=1), regardless of state:
  - state=IDLE, counter=0, hit flag=0.
  - readdata=DEFAULT_DATA, readdatavalid=0, rd_err=0.
  - waitrequest=1.
- A read in progress when reset asserts is dropped; no valid pulse is ever produced for it.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - read=1 -> go WAIT; counter <= READ_LATENCY-1; hit flag <= addr_hit.
  - read=0 -> stay IDLE.
- WAIT:
  - hit flag <= hit flag | addr_hit (sticky across the wait window).
  - If read drops to 0 (master abort) -> IDLE; no capture, no pulses, readdata unchanged.
  - Else if counter==0 -> capture and go DONE:
    - readdata <= data_in if (hit flag | addr_hit), else DEFAULT_DATA.
  - Else counter decrements.
- DONE:
  - waitrequest=0, readdatavalid=1.
  - rd_err=1 iff the captured hit was 0.
  - Unconditionally -> IDLE next cycle.
  - A read still high in the following IDLE cycle is treated as a new request; the master must drop read after the completion cycle.
- Output decoding:
  - waitrequest = ~(state==DONE); registered-state decode, no combinational path from read.
  - readdatavalid and rd_err are high only in DONE.
- Latency: read first high at cycle 0 -> DONE (waitrequest=0, readdatavalid=1) at cycle READ_LATENCY+1.
- readdata holds its last captured value between reads; it does not clear on return to IDLE.
- Counter width: 4 bits; READ_LATENCY=1 gives a single WAIT cycle.
- data_in is sampled only in the final WAIT cycle; earlier values are ignored.
- Back-to-back reads: minimum spacing is READ_LATENCY+2 cycles (IDLE re-entry is mandatory).

Test Plan:
- Reset: hold reset 3 cycles -> readdata=0x0000, readdatavalid=0, rd_err=0, waitrequest=1; release with read=0 -> outputs unchanged.
- Basic read, READ_LATENCY=2: read=1 at cycle 0, addr_hit=1, data_in=0xA5C3 from cycle 2 -> cycle 3: waitrequest=0, readdatavalid=1, readdata=0xA5C3, rd_err=0; cycle 4: readdatavalid=0, readdata still 0xA5C3.
- Late data: data_in=0x1111 in cycle 1, 0x2222 in cycle 2 -> captured readdata=0x2222.
- No hit: read with addr_hit=0 throughout, data_in=0xFFFF -> cycle 3: readdata=0x0000, readdatavalid=1, rd_err=1.
- Hit pulse only in cycle 1, data_in=0x00F0 -> readdata=0x00F0, rd_err=0 (sticky hit).
- Abort and reset mid-read:
  - read drops in cycle 2 -> no readdatavalid, readdata keeps previous 0xA5C3.
  - Separately, reset in WAIT -> IDLE next cycle, readdata=0x0000, no pulse.
- READ_LATENCY=1 build: read at cycle 0 -> completion at cycle 2; two back-to-back reads complete at cycles 2 and 5.
